// File: rtl/multi_lane_distributer.sv
// Multi-lane distributer: stripes a serial symbol stream across LANES lanes on TX,
// serialises lane-parallel words back to symbols on RX; ordered sets pass through whole.
module multi_lane_distributer #(
  parameter int LANES = 2,
  parameter int W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_t,
  input  logic                 enable_r,
  input  logic                 data_mode,
  input  logic [W-1:0]         tx_in_data,
  input  logic                 tx_in_valid,
  output logic                 tx_in_ready,
  input  logic [LANES*W-1:0]   tx_os_in,
  input  logic                 tx_os_valid,
  input  logic                 tx_flush,
  output logic [LANES*W-1:0]   tx_lanes_out,
  output logic                 tx_out_valid,
  input  logic                 tx_out_ready,
  input  logic [LANES*W-1:0]   rx_lanes_in,
  input  logic                 rx_in_valid,
  output logic                 rx_in_ready,
  output logic [LANES*W-1:0]   rx_out_data,
  output logic                 rx_out_valid,
  input  logic                 rx_out_ready,
  output logic                 rx_out_last,
  output logic                 rx_lanes_on,
  output logic [15:0]          rx_word_count
);

  localparam int DW = LANES * W;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES + 1);

  // Handshake rule for every stream here: a transfer happens on a rising edge
  // where valid && ready; valid/data hold until that edge, ready may depend on valid.

  logic mode_q;
  logic mode_chg;

  // TX state
  logic [DW-1:0] tx_slots;
  logic [IW-1:0] tx_idx;
  logic          tx_flush_pend;

  logic          tx_out_free;
  logic          tx_accept;
  logic [DW-1:0] tx_base_slots;
  logic [IW-1:0] tx_base_idx;
  logic [DW-1:0] tx_new_slots;
  logic [CW-1:0] tx_cnt;
  logic          tx_flush_req;
  logic          tx_emit_full;
  logic          tx_emit_part;
  logic          tx_pend_next;

  // RX state
  logic          rx_busy;
  logic [DW-1:0] rx_word;
  logic [IW-1:0] rx_lane;
  logic [W-1:0]  rx_sym [LANES];
  logic [IW-1:0] rx_next_lane;
  logic          rx_accept;
  logic          rx_out_fire;

  assign mode_chg = (data_mode != mode_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= 1'b0;
    else      mode_q <= data_mode;
  end

  // ---------------------------------------------------------------- TX side
  assign tx_out_free = !tx_out_valid || tx_out_ready;
  assign tx_in_ready = enable_t && data_mode && tx_out_free;
  assign tx_accept   = tx_in_valid && tx_in_ready;

  always_comb begin
    // A mode change drops the partial word; a symbol taken on that edge starts a fresh one.
    tx_base_slots = mode_chg ? '0 : tx_slots;
    tx_base_idx   = mode_chg ? '0 : tx_idx;
    tx_new_slots  = tx_base_slots;
    if (tx_accept) tx_new_slots[tx_base_idx*W +: W] = tx_in_data;
    tx_cnt        = CW'(tx_base_idx) + CW'(tx_accept);
    tx_flush_req  = tx_flush || (tx_flush_pend && !mode_chg);
    tx_emit_full  = (tx_cnt == CW'(LANES));
    tx_emit_part  = tx_flush_req && (tx_cnt != '0) && tx_out_free && !tx_emit_full;
    tx_pend_next  = tx_flush_req && (tx_cnt != '0) && !tx_out_free;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_slots      <= '0;
      tx_idx        <= '0;
      tx_flush_pend <= 1'b0;
      tx_lanes_out  <= '0;
      tx_out_valid  <= 1'b0;
    end else if (!enable_t) begin
      tx_slots      <= '0;
      tx_idx        <= '0;
      tx_flush_pend <= 1'b0;
      tx_lanes_out  <= '0;
      tx_out_valid  <= 1'b0;
    end else if (data_mode) begin
      if (tx_emit_full || tx_emit_part) begin
        // Slots return to zero so the unfilled lanes of a later partial word read 0.
        tx_lanes_out <= tx_new_slots;
        tx_out_valid <= 1'b1;
        tx_slots     <= '0;
        tx_idx       <= '0;
      end else begin
        tx_slots <= tx_new_slots;
        tx_idx   <= IW'(tx_cnt);
        if (tx_out_valid && tx_out_ready) tx_out_valid <= 1'b0;
      end
      tx_flush_pend <= tx_pend_next;
    end else begin
      tx_slots      <= '0;
      tx_idx        <= '0;
      tx_flush_pend <= 1'b0;
      if (tx_os_valid && tx_out_free) begin
        tx_lanes_out <= tx_os_in;
        tx_out_valid <= 1'b1;
      end else if (tx_out_valid && tx_out_ready) begin
        tx_out_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- RX side
  assign rx_out_fire = rx_out_valid && rx_out_ready;

  always_comb begin
    if (!enable_r)      rx_in_ready = 1'b0;
    else if (data_mode) rx_in_ready = !rx_busy || (rx_out_fire && rx_out_last);
    else                rx_in_ready = !rx_out_valid || rx_out_ready;
  end

  assign rx_accept = rx_in_valid && rx_in_ready;

  always_comb begin
    for (int k = 0; k < LANES; k++) rx_sym[k] = rx_word[k*W +: W];
    rx_next_lane = (rx_lane == IW'(LANES - 1)) ? '0 : rx_lane + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_busy       <= 1'b0;
      rx_word       <= '0;
      rx_lane       <= '0;
      rx_out_data   <= '0;
      rx_out_valid  <= 1'b0;
      rx_out_last   <= 1'b0;
      rx_word_count <= '0;
      rx_lanes_on   <= 1'b0;
    end else begin
      rx_lanes_on <= enable_r;
      if (!enable_r) begin
        rx_busy      <= 1'b0;
        rx_word      <= '0;
        rx_lane      <= '0;
        rx_out_data  <= '0;
        rx_out_valid <= 1'b0;
        rx_out_last  <= 1'b0;
      end else if (data_mode) begin
        if (rx_out_fire && rx_out_last && !mode_chg) rx_word_count <= rx_word_count + 16'd1;
        if (rx_accept) begin
          rx_word      <= rx_lanes_in;
          rx_lane      <= '0;
          rx_out_data  <= DW'(rx_lanes_in[W-1:0]);
          rx_out_valid <= 1'b1;
          rx_out_last  <= (LANES == 1);
          rx_busy      <= 1'b1;
        end else if (mode_chg) begin
          rx_busy      <= 1'b0;
          rx_lane      <= '0;
          rx_out_valid <= 1'b0;
          rx_out_last  <= 1'b0;
        end else if (rx_out_fire) begin
          if (rx_out_last) begin
            rx_busy      <= 1'b0;
            rx_lane      <= '0;
            rx_out_valid <= 1'b0;
            rx_out_last  <= 1'b0;
          end else begin
            rx_lane     <= rx_next_lane;
            rx_out_data <= DW'(rx_sym[rx_next_lane]);
            rx_out_last <= (rx_next_lane == IW'(LANES - 1));
          end
        end
      end else begin
        rx_busy <= 1'b0;
        rx_lane <= '0;
        if (rx_accept) begin
          rx_out_data  <= rx_lanes_in;
          rx_out_valid <= 1'b1;
          rx_out_last  <= 1'b1;
        end else if (mode_chg || rx_out_fire) begin
          rx_out_valid <= 1'b0;
          rx_out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/multi_lane_distributer.md
MULTI_LANE_DISTRIBUTER -- requirements
Module: multi_lane_distributer

Interface
REQ-001 SHALL have parameter LANES, default 2, number of physical lanes; legal values 1, 2, 4.
REQ-002 SHALL have parameter W, default 8, symbol width per lane in bits.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_t  input  1  transmit-side enable.
REQ-006 SHALL have port enable_r  input  1  receive-side enable.
REQ-007 SHALL have port data_mode  input  1  1 = transport-data striping, 0 = ordered-set pass-through.
REQ-008 SHALL have ports tx_in_data  input  W, tx_in_valid  input  1, tx_in_ready  output  1  serial data-mode symbol stream.
REQ-009 SHALL have ports tx_os_in  input  LANES*W, tx_os_valid  input  1  ordered-set word; lane k occupies bits [k*W +: W].
REQ-010 SHALL have port tx_flush  input  1  single-cycle pulse that emits a partial data word.
REQ-011 SHALL have ports tx_lanes_out  output  LANES*W, tx_out_valid  output  1, tx_out_ready  input  1  lane-parallel transmit word.
REQ-012 SHALL have ports rx_lanes_in  input  LANES*W, rx_in_valid  input  1, rx_in_ready  output  1  lane-parallel receive word.
REQ-013 SHALL have ports rx_out_data  output  LANES*W, rx_out_valid  output  1, rx_out_ready  input  1, rx_out_last  output  1  receive output; data mode uses bits [W-1:0] only.
REQ-014 SHALL have ports rx_lanes_on  output  1 and rx_word_count  output  16  status.

Function
REQ-015 TX data mode: tx_in_ready = enable_t && (!tx_out_valid || tx_out_ready).
- Each accepted symbol (valid && ready) is written to slot tx_idx, then tx_idx increments.
- Accepting the symbol with tx_idx = LANES-1 raises tx_out_valid on the next cycle, carrying the assembled word; tx_idx wraps to 0.
REQ-016 tx_lanes_out and tx_out_valid SHALL hold stable while tx_out_valid && !tx_out_ready; tx_out_valid clears one cycle after acceptance unless a new word completes in that same cycle.
REQ-017 tx_flush with tx_idx != 0 SHALL emit the partial word next cycle, with unfilled slots set to 0, and reset tx_idx to 0.
- Flush with tx_idx = 0 has no effect.
- Flush coincident with an accepted symbol includes that symbol first.
- Flush while tx_out_valid && !tx_out_ready is held pending until the output is accepted.
REQ-018 TX ordered-set mode:
- tx_in_ready = 0.
- tx_os_valid && (!tx_out_valid || tx_out_ready) registers tx_os_in onto tx_lanes_out with tx_out_valid on the next cycle (latency 1).
REQ-019 Any data_mode change SHALL discard the partial TX word, clear tx_idx, and clear the slot registers. A word already valid on the output SHALL still complete its handshake.
REQ-020 enable_t low SHALL synchronously clear tx_idx, the slots, tx_out_valid, tx_lanes_out and pending flush, and force tx_in_ready = 0.
REQ-021 RX data mode: rx_in_ready = enable_r && (!rx_busy || (rx_out_valid && rx_out_ready && rx_out_last)).
- An accepted word is captured, and rx_busy is set.
- Lanes 0..LANES-1 are emitted in order on rx_out_data[W-1:0], one per rx_out_ready handshake; upper bits are 0.
- The first symbol appears the cycle after capture.
REQ-022 rx_out_last SHALL be 1 exactly while lane LANES-1 is presented.
- Its acceptance increments rx_word_count, which wraps from 16'hFFFF to 0.
- Its acceptance clears rx_busy unless a new word is captured in the same cycle, in which case lane 0 of the new word follows with no bubble.
REQ-023 RX ordered-set mode:
- rx_in_ready = enable_r && (!rx_out_valid || rx_out_ready).
- The word is forwarded whole on rx_out_data with 1-cycle latency.
- rx_out_last = 1.
- rx_word_count is unchanged.
REQ-024 A data_mode change SHALL abort any RX word in progress: rx_busy, rx_out_valid and the lane index are cleared.
REQ-025 enable_r low SHALL synchronously clear all RX state, rx_out_data, rx_out_valid and rx_out_last, and force rx_in_ready = 0; rx_word_count is held.
REQ-026 rx_lanes_on SHALL be enable_r registered by one cycle.
REQ-027 With LANES = 1, data mode SHALL degenerate to a 1-cycle registered pass-through with rx_out_last = 1 on every symbol.

Reset
REQ-028 rst low SHALL immediately force to 0: tx_lanes_out, tx_out_valid, rx_out_data, rx_out_valid, rx_out_last, rx_lanes_on, rx_word_count, tx_idx, rx_busy and all slot registers.
REQ-029 The first rising edge after rst deasserts SHALL behave as if the block had been idle.

Verification
REQ-030 LANES=2, data mode, tx_out_ready=1, symbols 0xA1, 0xB2 on consecutive cycles -> tx_lanes_out = 0xB2A1 with tx_out_valid for 1 cycle, one cycle after 0xB2 is accepted.
REQ-031 LANES=4, symbols 0x11, 0x22, 0x33, then tx_flush -> tx_lanes_out = 0x00332211; the next symbol lands in lane 0.
REQ-032 LANES=2, tx_out_ready=0 for 3 cycles with a word pending -> tx_in_ready=0 and tx_lanes_out stable; when ready rises, the word is accepted once.
REQ-033 LANES=4, RX data mode, two back-to-back words 0x44332211 and 0x88776655, rx_out_ready=1 -> rx_out_data = 0x11..0x88 on 8 consecutive cycles, rx_out_last on 0x44 and 0x88, rx_word_count = 2.
REQ-034 Ordered-set mode, tx_os_in = 0x5A5A with tx_os_valid -> tx_lanes_out = 0x5A5A next cycle; switching to data mode after 1 of 2 symbols then sending 0xC3, 0xD4 -> output 0xD4C3 (partial discarded).
REQ-035 rst pulsed low mid-RX word, and enable_t dropped mid-TX word -> all outputs 0 immediately; no stale word emitted after recovery.
